spmv_row_accumulator: RTL

Row-sum scheduler behind the multiplier channels of the sparse matrix-vector engine. It drains the per-channel product FIFOs in strict round-robin element order, accumulates the signed products of each matrix row into one shared accumulator, and emits one result per row. It sits between the channel product FIFOs (`mult` / `mult_fifo_empty` / `mult_fifo_read`) and the result writeback. Row lengths come from a row-length FIFO.

---
 rtl/spmv_row_accumulator_pkg.sv | 26 ++
 rtl/spmv_row_accumulator_rr_pointer.sv | 41 ++++
 rtl/spmv_row_accumulator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/spmv_row_accumulator_pkg.sv
// rtl/spmv_row_accumulator_pkg.sv - shared parameters and state encoding for the SpMV row accumulator
//
// Purpose: default channel count and operand width for the multiplier
// channels, the row-accumulator FSM state encoding (shared with the bench),
// and a pointer-width helper.
// Ports: none (package).

package spmv_row_accumulator_pkg;

  localparam int default_channel_num = 4;
  localparam int default_val_bits    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEN_WAIT = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_EMIT     = 3'd4
  } state_e;

  // A single-channel build still needs a 1-bit pointer to keep ranges legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spmv_row_accumulator_rr_pointer.sv
// rtl/spmv_row_accumulator_rr_pointer.sv - modulo-channel_num round-robin pointer with one-hot decode
//
// Purpose: channel pointer that advances by one (wrapping channel_num-1 to 0)
// each cycle advance is high; also presents the pointer as a one-hot vector.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer returns to 0)
//   advance   : step the pointer this cycle
//   ptr       : current channel index
//   onehot    : one-hot decode of ptr

module rr_pointer
  import spmv_row_accumulator_pkg::*;
#(
  parameter int channel_num = default_channel_num
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               advance,
  output logic [ptr_width(channel_num)-1:0]  ptr,
  output logic [channel_num-1:0]             onehot
);

  localparam int ptr_bits = ptr_width(channel_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == ptr_bits'(channel_num - 1)) ? '0 : ptr + ptr_bits'(1);
    end
  end

  // Compare-based decode stays in range for non power-of-two channel counts.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < channel_num; i++) begin
      onehot[i] = (ptr == ptr_bits'(i));
    end
  end

endmodule

// File: rtl/spmv_row_accumulator.sv
// rtl/spmv_row_accumulator.sv - round-robin row-sum scheduler behind the SpMV multiplier channels
//
// Purpose: reads row lengths from the length FIFO, drains the per-channel
// product FIFOs in strict global round-robin element order, accumulates the
// signed products of each row and presents one result per row.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mult / mult_fifo_empty   : per-channel product FIFO data and empty flags
//   mult_fifo_read           : per-channel read strobes (at most one high)
//   len / len_fifo_empty     : row-length FIFO data and empty flag
//   len_fifo_read            : row-length FIFO read strobe
//   res / res_row            : row sum and its row index
//   res_valid / res_ready    : result handshake

module spmv_row_accumulator
  import spmv_row_accumulator_pkg::*;
#(
  parameter int channel_num = default_channel_num,
  parameter int val_bits    = default_val_bits,
  parameter int acc_bits    = 32,
  parameter int len_bits    = 16,
  parameter int row_bits    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*val_bits*channel_num-1:0] mult,
  input  logic [channel_num-1:0]            mult_fifo_empty,
  output logic [channel_num-1:0]            mult_fifo_read,
  input  logic [len_bits-1:0]               len,
  input  logic                              len_fifo_empty,
  output logic                              len_fifo_read,
  output logic [acc_bits-1:0]               res,
  output logic [row_bits-1:0]               res_row,
  output logic                              res_valid,
  input  logic                              res_ready
);

  localparam int prod_bits = 2 * val_bits;
  localparam int ptr_bits  = ptr_width(channel_num);

  state_e                      state;
  state_e                      state_next;
  logic [len_bits-1:0]         remaining;
  logic                        data_pending;
  logic [ptr_bits-1:0]         ptr;
  logic [ptr_bits-1:0]         ptr_prev;
  logic [channel_num-1:0]      ptr_onehot;
  logic                        rd_issue;
  logic signed [acc_bits-1:0]  acc;
  logic [row_bits-1:0]         row_q;
  logic signed [prod_bits-1:0] prod_sel;
  logic signed [acc_bits-1:0]  prod_ext;

  // The pointer is never cleared between rows: element k of the whole
  // matrix stream always lives in channel k mod channel_num.
  rr_pointer #(
    .channel_num (channel_num)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (rd_issue),
    .ptr     (ptr),
    .onehot  (ptr_onehot)
  );

  always_comb begin
    state_next    = state;
    len_fifo_read = 1'b0;
    rd_issue      = 1'b0;
    res_valid     = 1'b0;
    case (state)
      ST_IDLE: begin
        len_fifo_read = ~len_fifo_empty;
        if (!len_fifo_empty) state_next = ST_LEN_WAIT;
      end
      ST_LEN_WAIT: begin
        state_next = (len == '0) ? ST_EMIT : ST_ACCUM;
      end
      ST_ACCUM: begin
        // An empty current channel stalls; other channels are never tried.
        rd_issue = ~mult_fifo_empty[ptr] & (remaining != '0);
        if (rd_issue && (remaining == len_bits'(1))) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    mult_fifo_read = rd_issue ? ptr_onehot : '0;
  end

  // Data arrives one cycle after its read strobe, so the product is picked
  // from the channel that was read last cycle, not the current pointer.
  always_comb begin
    prod_sel = mult[int'(ptr_prev) * prod_bits +: prod_bits];
    prod_ext = acc_bits'(prod_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      data_pending <= 1'b0;
      ptr_prev     <= '0;
      acc          <= '0;
      row_q        <= '0;
    end else begin
      state        <= state_next;
      data_pending <= rd_issue;
      if (rd_issue) begin
        ptr_prev  <= ptr;
        remaining <= remaining - len_bits'(1);
      end
      if (state == ST_LEN_WAIT) begin
        remaining <= len;
        acc       <= '0;
      end else if (data_pending) begin
        acc <= acc + prod_ext;
      end
      if (state == ST_EMIT && res_ready) begin
        row_q <= row_q + row_bits'(1);
      end
    end
  end

  assign res     = acc;
  assign res_row = row_q;

endmodule
